// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle adder processing CHUNK bits per clock
// Latches operands, ripples one chunk per RUN cycle, holds the result in DONE until accepted.
module serial_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NCH  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
   localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("serial_chunk_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, b_q, sum_q;
   logic              carry_q, cout_q, ovf_q;
   logic [IDXW-1:0]   idx_q;
   logic [CHUNK-1:0]  a_chunk, b_chunk, chunk_sum;
   logic [CHUNK:0]    carry;
   logic              last_chunk;

   assign last_chunk = (idx_q == IDXW'(NCH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (last_chunk) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // in_ready is gated by rst_n so it reads low while reset is held
   always_comb begin
      in_ready  = rst_n && (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == RUN);
   end

   // Chunk select plus CHUNK-bit ripple of full adders seeded by the carry register
   always_comb begin
      a_chunk   = '0;
      b_chunk   = '0;
      chunk_sum = '0;
      carry     = '0;
      for (int k = 0; k < NCH; k++) begin
         if (idx_q == IDXW'(k)) begin
            a_chunk = a_q[k*CHUNK +: CHUNK];
            b_chunk = b_q[k*CHUNK +: CHUNK];
         end
      end
      carry[0] = carry_q;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_sum[i] = a_chunk[i] ^ b_chunk[i] ^ carry[i];
         carry[i+1]   = (a_chunk[i] & b_chunk[i]) | (carry[i] & (a_chunk[i] ^ b_chunk[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  idx_q   <= '0;
                  sum_q   <= '0;
               end
            end
            RUN: begin
               for (int k = 0; k < NCH; k++) begin
                  if (idx_q == IDXW'(k)) sum_q[k*CHUNK +: CHUNK] <= chunk_sum;
               end
               carry_q <= carry[CHUNK];
               // idx stops on the last chunk so it can never wrap
               if (last_chunk) begin
                  cout_q <= carry[CHUNK];
                  ovf_q  <= carry[CHUNK] ^ carry[CHUNK-1];
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - self-checking bench for serial_chunk_adder
// Three instances (8/4, 32/8, 16/16) share clock, reset and operand buses.
module tb_serial_chunk_adder;

   logic        clk;
   logic        rst_n;
   logic [31:0] a_d, b_d;
   logic        cin_d;
   logic [2:0]  iv, ordy, ov, ir, bz, co, of;
   logic [7:0]  s0;
   logic [31:0] s1;
   logic [15:0] s2;
   logic [31:0] sumv [3];
   int          passed, total;

   assign sumv[0] = {24'b0, s0};
   assign sumv[1] = s1;
   assign sumv[2] = {16'b0, s2};

   serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(a_d[7:0]), .b(b_d[7:0]), .cin(cin_d), .out_valid(ov[0]), .out_ready(ordy[0]),
      .sum(s0), .cout(co[0]), .ovf(of[0]), .busy(bz[0]));

   serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_w32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(a_d), .b(b_d), .cin(cin_d), .out_valid(ov[1]), .out_ready(ordy[1]),
      .sum(s1), .cout(co[1]), .ovf(of[1]), .busy(bz[1]));

   serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(a_d[15:0]), .b(b_d[15:0]), .cin(cin_d), .out_valid(ov[2]), .out_ready(ordy[2]),
      .sum(s2), .cout(co[2]), .ovf(of[2]), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int wid(input int k);
      return (k == 0) ? 8 : ((k == 1) ? 32 : 16);
   endfunction

   function automatic int nch(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
   endfunction

   // Reference: plain wide addition; ovf from the sign rule of two's complement addition
   task automatic model(input int w, input logic [31:0] a, b, input logic c,
                        output logic [31:0] s, output logic cy, output logic ov_e);
      longint unsigned m, t;
      m    = (64'd1 << w) - 1;
      t    = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
      s    = 32'(t & m);
      cy   = t[w];
      ov_e = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic start_op(input int k, input logic [31:0] a, b, input logic c);
      int n;
      n = 0;
      while (!ir[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_start", {31'b0, ir[k]}, 32'd1);
      a_d = a; b_d = b; cin_d = c; iv[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[k] = 1'b0;
   endtask

   // Scrambles inputs and out_ready while running: both must be ignored outside their states
   task automatic wait_done(input int k, output int lat, output int bc);
      lat = 0; bc = 0;
      while (!ov[k] && lat < 64) begin
         if (bz[k]) bc++;
         a_d = $urandom; b_d = $urandom; cin_d = 1'($urandom);
         iv[k] = 1'($urandom); ordy[k] = 1'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      iv[k] = 1'b0; ordy[k] = 1'b0;
      if (!ov[k]) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic pop(input int k);
      ordy[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy[k] = 1'b0;
      chk("out_valid_after_pop", {31'b0, ov[k]}, 32'd0);
      chk("in_ready_after_pop", {31'b0, ir[k]}, 32'd1);
   endtask

   task automatic do_op(input int k, input logic [31:0] a, b, input logic c,
                        input logic [31:0] es, input logic eco, input logic eof);
      int lat, bc;
      start_op(k, a, b, c);
      wait_done(k, lat, bc);
      chk("sum", sumv[k], es);
      chk("cout", {31'b0, co[k]}, {31'b0, eco});
      chk("ovf", {31'b0, of[k]}, {31'b0, eof});
      chk("latency", lat, nch(k));
      chk("busy_cycles", bc, nch(k));
      chk("in_ready_in_done", {31'b0, ir[k]}, 32'd0);
      pop(k);
   endtask

   typedef struct {
      int          k;
      logic [31:0] a, b;
      logic        c;
      logic [31:0] s;
      logic        co, of;
   } vec_t;

   vec_t vt [9];

   initial begin
      logic [31:0] es, held;
      logic        eco, eof;
      int          n, seen;

      vt[0] = '{0, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0};
      vt[1] = '{0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1};
      vt[2] = '{0, 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, 1'b0};
      vt[3] = '{0, 32'h80, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1};
      vt[4] = '{1, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0};
      vt[5] = '{1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
      vt[6] = '{1, 32'h7FFFFFFF, 32'h0, 1'b1, 32'h80000000, 1'b0, 1'b1};
      vt[7] = '{2, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1};
      vt[8] = '{2, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFF, 1'b1, 1'b0};

      passed = 0; total = 0;
      rst_n = 1'b0; iv = '0; ordy = '0; a_d = '0; b_d = '0; cin_d = 1'b0;
      #12;
      chk("rst_in_ready_low", {29'b0, ir}, 32'd0);
      chk("rst_out_valid", {29'b0, ov}, 32'd0);
      chk("rst_busy", {29'b0, bz}, 32'd0);
      chk("rst_cout_ovf", {26'b0, co, of}, 32'd0);
      chk("rst_sum32", sumv[1], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_rst", {29'b0, ir}, 32'd7);
      @(negedge clk);

      for (int i = 0; i < 9; i++)
         do_op(vt[i].k, vt[i].a, vt[i].b, vt[i].c, vt[i].s, vt[i].co, vt[i].of);

      // Backpressure: result must hold while out_ready stays low and inputs toggle
      start_op(1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
      wait_done(1, n, seen);
      model(32, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, es, eco, eof);
      held = es;
      for (int i = 0; i < 5; i++) begin
         a_d = $urandom; b_d = $urandom; iv[1] = 1'($urandom); ordy[1] = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("bp_sum", sumv[1], held);
         chk("bp_flags", {29'b0, ov[1], co[1], of[1]}, {29'b0, 1'b1, eco, eof});
         chk("bp_in_ready", {31'b0, ir[1]}, 32'd0);
      end
      iv[1] = 1'b0;
      pop(1);
      chk("sum_kept_after_done", sumv[1], held);

      // Reset two chunks into a run: everything returns to reset values, no result
      start_op(1, 32'hDEADBEEF, 32'h01234567, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sum", sumv[1], 32'd0);
      chk("midrst_flags", {28'b0, ov[1], co[1], of[1], bz[1]}, 32'd0);
      chk("midrst_in_ready", {31'b0, ir[1]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ov[1]) seen++;
      end
      chk("midrst_no_result", seen, 32'd0);
      do_op(1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

      // Random back-to-back operations against the reference model
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            logic        rc;
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            model(wid(k), ra, rb, rc, es, eco, eof);
            do_op(k, ra, rb, rc, es, eco, eof);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per clock cycle.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands a, b, cin presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  addend A, unsigned or two's complement.
REQ-008 SHALL have port b  input  WIDTH  addend B.
REQ-009 SHALL have port cin  input  1  carry in.
REQ-010 SHALL have port out_valid  output  1  sum, cout and ovf are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  unsigned carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-015 SHALL have port busy  output  1  high in RUN state.

Function
REQ-016 SHALL enforce at elaboration: CHUNK>=1, CHUNK<=WIDTH, WIDTH % CHUNK == 0; NCH = WIDTH/CHUNK.
REQ-017 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1, out_valid=0, busy=0; in_valid=1 at an edge latches a, b, cin into internal registers, clears chunk index to 0, clears sum register to 0, enters RUN.
REQ-019 RUN: in_ready=0, busy=1; each edge adds chunk [idx*CHUNK +: CHUNK] of latched a and b with the carry register via a CHUNK-bit ripple of full adders, writes that sum chunk, stores the chunk carry-out, increments idx.
REQ-020 RUN SHALL transition to DONE on the edge that processes chunk NCH-1; that edge also registers cout and ovf (ovf from carry into and out of bit WIDTH-1).
REQ-021 Latency: out_valid SHALL rise exactly NCH edges after the accepting edge (CHUNK==WIDTH gives 1 edge).
REQ-022 DONE: out_valid=1, in_ready=0; sum, cout, ovf held stable until the handshake edge.
REQ-023 DONE with out_ready=1 at an edge SHALL drop out_valid and return to IDLE; in_ready rises the cycle after, never in the same cycle as out_valid (no same-cycle result/accept overlap).
REQ-024 in_valid SHALL be ignored outside IDLE; changes to a, b, cin after acceptance SHALL NOT affect the result.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 sum, cout, ovf SHALL keep their last values after leaving DONE until overwritten by the next operation's partial writes (sum cleared on accept).
REQ-027 Chunk index SHALL be $clog2(NCH) bits minimum (1 bit if NCH==1) and never wrap during a RUN.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, in_ready=1 (once rst_n high), out_valid=0, busy=0, sum=0, cout=0, ovf=0, carry register=0, idx=0.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation with no result emitted.
REQ-030 While rst_n=0, in_ready SHALL read 0.

Verification
REQ-031 WIDTH=8, CHUNK=4: a=0x0F, b=0x01, cin=0 -> out_valid 2 edges after accept, sum=0x10, cout=0, ovf=0.
REQ-032 WIDTH=8, CHUNK=4: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
REQ-033 WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0, cout=1, ovf=0, out_valid 4 edges after accept, busy high exactly 4 cycles.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE, toggle a/b/in_valid -> outputs stable, in_ready=0; then out_ready=1 -> out_valid falls next edge, in_ready rises.
REQ-035 Reset mid-RUN (WIDTH=32, CHUNK=8, after 2 chunks) -> all outputs at reset values, no out_valid; next operation 0x12345678+0x11111111 -> sum=0x23456789.
REQ-036 CHUNK=WIDTH=16: 0x8000+0x8000 -> out_valid 1 edge after accept, sum=0x0000, cout=1, ovf=1; random back-to-back operations match a reference a+b+cin model.
